tt_um_hoene_led_capture: RTL and testbench
==========================================

# tt_um_hoene_led_capture

Downstream stage of the protocol bit/LED counter in the smart-LED chain. It consumes the delayed data, clock-strobe and frame signals together with the bit index and test-mode flag. It captures the first 32-bit word of each frame as this chip's LED setting and forwards all later bits to the next chip in the chain. At frame end it latches a complete captured word onto the LED colour outputs; in test mode it drives a ramp pattern instead.

## Interface
- No parameters; word width fixed at 32 bits (4 × 8-bit fields).
- clk  in  1  global clock
- rst_n  in  1  asynchronous active-low reset
- in_clk  in  1  bit strobe, synchronous to clk; high one or more cycles per bit, one bit accepted per high cycle
- in_data  in  1  serial data bit, valid while in_clk=1
- in_frame  in  1  frame active; low = idle / counters reset
- bit_counter  in  5  index (0..31) of the bit strobed in the current cycle, 0 = first/MSB of a word
- test_mode  in  1  upstream test-mode flag (too many LED words in frame)
- led_bright  out  8  latched brightness
- led_red  out  8  latched red
- led_green  out  8  latched green
- led_blue  out  8  latched blue
- led_update  out  1  one-cycle pulse when LED outputs change at frame end
- out_data  out  1  forwarded data to next chip
- out_clk  out  1  forwarded bit strobe (gated during capture)
- out_frame  out  1  forwarded frame

## Operation
- Word format, MSB first: [31:24] bright, [23:16] red, [15:8] green, [7:0] blue.
- States: IDLE, CAPTURE, FORWARD, TEST. All outputs are registered.
- IDLE: shift register cleared, word_full=0. in_frame=1 → CAPTURE.
- CAPTURE: on each cycle with in_frame=1 and in_clk=1, shift_reg <= {shift_reg[30:0], in_data}. When bit_counter==31 on a strobe, set word_full=1 and go to FORWARD. out_clk is held 0 and out_data is held 0.
- FORWARD: out_data <= in_data and out_clk <= in_clk each cycle.
- out_frame <= in_frame in every state, including CAPTURE.
- Any state with in_frame=1 and test_mode=1 → TEST. TEST has priority over the CAPTURE and FORWARD transitions.
- TEST:
  - Forwarding continues as in FORWARD.
  - An 8-bit ramp increments on each strobe and wraps at 0xFF → 0x00.
  - On each strobe: led_red = led_green = led_blue = ramp value after the increment, led_bright = 0xFF.
  - led_update is not pulsed in TEST.
- Frame end: in_frame observed 0 while state ≠ IDLE → IDLE. Also:
  - From CAPTURE/FORWARD with word_full=1: load LED outputs from shift_reg and pulse led_update.
  - word_full=0 (partial word): discard the word; outputs hold.
  - From TEST: outputs hold the last pattern. The ramp is not reset; it is cleared only by rst_n.
- While in_frame=0: out_data=0, out_clk=0, out_frame=0.
- Reset (rst_n=0, asynchronous):
  - State IDLE; shift_reg, word_full and ramp = 0.
  - All LED outputs 0; led_update, out_data, out_clk, out_frame = 0.
  - Reset mid-frame aborts the capture; nothing is latched after release.

## Timing
- Forwarding latency: out_* appear exactly 1 clk after the in_* values.
- The 32nd captured bit is strobed at edge N. The state is FORWARD from edge N, so a strobe at edge N+1 is forwarded (out_clk=1 after edge N+1).
- Frame end: in_frame low sampled at edge M. New LED values and led_update=1 are valid after edge M, and led_update returns to 0 after edge M+1.
- A strobe in the same cycle as in_frame=0 is ignored.
- test_mode and the 32nd bit in the same cycle: TEST wins, but that 32nd bit is still shifted in. word_full is irrelevant because TEST does not latch.
- A multi-cycle-high in_clk counts one bit per high cycle. Upstream guarantees single-cycle strobes.

## Test plan
- Reset: assert rst_n=0 mid-frame → all outputs 0 immediately; after release, a frame of 0xFF102030 → bright=0xFF, red=0x10, green=0x20, blue=0x30, with a single led_update pulse one cycle after in_frame falls.
- Chain forward: frame of 3 words (0x11223344, 0xAAAAAAAA, 0x55555555) → LEDs = 0x11223344; out_clk pulses exactly 64 times; forwarded bits equal words 2 and 3, delayed 1 clk; out_frame is in_frame delayed 1 clk.
- Partial word: frame ends after 20 bits → LED outputs unchanged, no led_update, out_clk never high.
- Test mode: test_mode raised after 5 strobes of a frame, then 300 further strobes → led_red = led_green = led_blue = 300 mod 256 = 0x2C, bright=0xFF; frame end produces no led_update and the values hold.
- Back-to-back frames: 0x01020304, in_frame low for 1 cycle, then 0x05060708 → two led_update pulses, final LEDs = 0x05060708.

Source files
------------

// File: rtl/tt_um_hoene_led_capture_if.sv
// rtl/tt_um_hoene_led_capture_if.sv - serial LED chain bundle: upstream bit stream in, LED word and forwarded stream out
interface tt_um_hoene_led_capture_if;
  logic       in_clk;
  logic       in_data;
  logic       in_frame;
  logic [4:0] bit_counter;
  logic       test_mode;
  logic [7:0] led_bright;
  logic [7:0] led_red;
  logic [7:0] led_green;
  logic [7:0] led_blue;
  logic       led_update;
  logic       out_data;
  logic       out_clk;
  logic       out_frame;

  modport master (
    output in_clk, in_data, in_frame, bit_counter, test_mode,
    input  led_bright, led_red, led_green, led_blue, led_update,
    input  out_data, out_clk, out_frame
  );

  modport slave (
    input  in_clk, in_data, in_frame, bit_counter, test_mode,
    output led_bright, led_red, led_green, led_blue, led_update,
    output out_data, out_clk, out_frame
  );
endinterface

// File: rtl/tt_um_hoene_led_capture.sv
// rtl/tt_um_hoene_led_capture.sv - captures the first 32-bit word of a frame as LED colour, forwards the rest
// Latches the captured word at frame end; test mode overrides the LEDs with a strobe-driven grey ramp.
module tt_um_hoene_led_capture (
  input logic                           clk,
  input logic                           rst_n,
  tt_um_hoene_led_capture_if.slave      bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FORWARD = 2'd2;
  localparam logic [1:0] ST_TEST    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic        full_q, full_d;
  logic [7:0]  ramp_q, ramp_d;
  logic [7:0]  led_bright_q, led_bright_d;
  logic [7:0]  led_red_q, led_red_d;
  logic [7:0]  led_green_q, led_green_d;
  logic [7:0]  led_blue_q, led_blue_d;
  logic        led_update_q, led_update_d;
  logic        out_data_q, out_data_d;
  logic        out_clk_q, out_clk_d;
  logic        out_frame_q, out_frame_d;
  logic        strobe;
  logic [7:0]  ramp_next;

  assign strobe    = bus.in_frame & bus.in_clk;
  assign ramp_next = ramp_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    full_d       = full_q;
    ramp_d       = ramp_q;
    led_bright_d = led_bright_q;
    led_red_d    = led_red_q;
    led_green_d  = led_green_q;
    led_blue_d   = led_blue_q;
    led_update_d = 1'b0;
    out_data_d   = 1'b0;
    out_clk_d    = 1'b0;
    out_frame_d  = bus.in_frame;

    if (!bus.in_frame) begin
      // Only a complete word reaches the LEDs; partial words and test frames leave them as they are.
      if ((state_q == ST_CAPTURE || state_q == ST_FORWARD) && full_q) begin
        led_bright_d = shift_q[31:24];
        led_red_d    = shift_q[23:16];
        led_green_d  = shift_q[15:8];
        led_blue_d   = shift_q[7:0];
        led_update_d = 1'b1;
      end
      state_d = ST_IDLE;
      shift_d = 32'd0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        // A bit strobed in the very first frame cycle is kept rather than lost.
        ST_IDLE: begin
          state_d = ST_CAPTURE;
          if (strobe) shift_d = {shift_q[30:0], bus.in_data};
        end
        ST_CAPTURE: begin
          if (strobe) begin
            shift_d = {shift_q[30:0], bus.in_data};
            if (bus.bit_counter == 5'd31) begin
              full_d  = 1'b1;
              state_d = ST_FORWARD;
            end
          end
        end
        ST_FORWARD: begin
          out_data_d = bus.in_data;
          out_clk_d  = bus.in_clk;
        end
        default: begin
          out_data_d = bus.in_data;
          out_clk_d  = bus.in_clk;
          if (strobe) begin
            ramp_d       = ramp_next;
            led_bright_d = 8'hFF;
            led_red_d    = ramp_next;
            led_green_d  = ramp_next;
            led_blue_d   = ramp_next;
          end
        end
      endcase
      if (bus.test_mode) state_d = ST_TEST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shift_q      <= 32'd0;
      full_q       <= 1'b0;
      ramp_q       <= 8'd0;
      led_bright_q <= 8'd0;
      led_red_q    <= 8'd0;
      led_green_q  <= 8'd0;
      led_blue_q   <= 8'd0;
      led_update_q <= 1'b0;
      out_data_q   <= 1'b0;
      out_clk_q    <= 1'b0;
      out_frame_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      full_q       <= full_d;
      ramp_q       <= ramp_d;
      led_bright_q <= led_bright_d;
      led_red_q    <= led_red_d;
      led_green_q  <= led_green_d;
      led_blue_q   <= led_blue_d;
      led_update_q <= led_update_d;
      out_data_q   <= out_data_d;
      out_clk_q    <= out_clk_d;
      out_frame_q  <= out_frame_d;
    end
  end

  assign bus.led_bright = led_bright_q;
  assign bus.led_red    = led_red_q;
  assign bus.led_green  = led_green_q;
  assign bus.led_blue   = led_blue_q;
  assign bus.led_update = led_update_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_clk    = out_clk_q;
  assign bus.out_frame  = out_frame_q;

endmodule

// File: tb/tb_tt_um_hoene_led_capture.sv
// tb/tb_tt_um_hoene_led_capture.sv - directed bench for the LED capture / chain forwarding stage
module tb_tt_um_hoene_led_capture;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   upd_cnt;
  int   fwd_cnt;
  int   mode;
  logic [63:0] fwd_bits;
  logic        tm;

  tt_um_hoene_led_capture_if bus ();

  tt_um_hoene_led_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] leds();
    return {bus.led_bright, bus.led_red, bus.led_green, bus.led_blue};
  endfunction

  // Apply one cycle of inputs, then observe the registered outputs just after the edge.
  task automatic step(input logic c, input logic d, input logic f, input logic [4:0] bc);
    bus.in_clk      = c;
    bus.in_data     = d;
    bus.in_frame    = f;
    bus.bit_counter = bc;
    bus.test_mode   = tm;
    @(posedge clk);
    #1;
    if (bus.led_update) upd_cnt++;
    if (bus.out_clk) begin
      fwd_cnt++;
      fwd_bits = {fwd_bits[62:0], bus.out_data};
    end
    chk("out_frame", 64'(bus.out_frame), 64'(f));
    if (mode == 1) chk("gated", {62'd0, bus.out_clk, bus.out_data}, 64'd0);
    if (mode == 2) chk("forward", {62'd0, bus.out_clk, bus.out_data}, {62'd0, c, d});
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, w[31-i], 1'b1, 5'(i));
      step(1'b0, 1'b0, 1'b1, 5'(i));
    end
  endtask

  initial begin
    checks = 0; errors = 0; upd_cnt = 0; fwd_cnt = 0; mode = 0; fwd_bits = '0; tm = 1'b0;
    bus.in_clk = 0; bus.in_data = 0; bus.in_frame = 0; bus.bit_counter = 0; bus.test_mode = 0;
    rst_n = 1'b0;
    #1;
    chk("reset_leds", 64'(leds()), 64'd0);
    chk("reset_outs", {60'd0, bus.led_update, bus.out_data, bus.out_clk, bus.out_frame}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset: latch a word, then reset mid-frame while forwarding
    step(0, 0, 1, 0);
    send_word(32'hDEADBEEF);
    step(0, 0, 0, 0);
    chk("pre_reset_leds", 64'(leds()), 64'hDEADBEEF);
    step(0, 0, 1, 0);
    send_word(32'h12345678);
    step(1, 1, 1, 0);
    chk("pre_reset_fwd", {62'd0, bus.out_clk, bus.out_data}, 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_leds", 64'(leds()), 64'd0);
    chk("async_outs", {60'd0, bus.led_update, bus.out_data, bus.out_clk, bus.out_frame}, 64'd0);
    upd_cnt = 0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("abort_no_update", 64'(upd_cnt), 64'd0);
    chk("abort_leds", 64'(leds()), 64'd0);
    step(0, 0, 1, 0);
    send_word(32'hFF102030);
    upd_cnt = 0;
    step(0, 0, 0, 0);
    chk("after_reset_upd", 64'(bus.led_update), 64'd1);
    chk("after_reset_leds", 64'(leds()), 64'hFF102030);
    step(0, 0, 0, 0);
    chk("after_reset_upd_low", 64'(bus.led_update), 64'd0);
    chk("after_reset_upd_cnt", 64'(upd_cnt), 64'd1);

    // Chain forward: first word captured, next two forwarded
    upd_cnt = 0; fwd_cnt = 0; fwd_bits = '0;
    mode = 1;
    step(0, 0, 1, 0);
    send_word(32'h11223344);
    mode = 2;
    send_word(32'hAAAAAAAA);
    send_word(32'h55555555);
    mode = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("chain_fwd_cnt", 64'(fwd_cnt), 64'd64);
    chk("chain_fwd_bits", fwd_bits, 64'hAAAAAAAA55555555);
    chk("chain_leds", 64'(leds()), 64'h11223344);
    chk("chain_upd_cnt", 64'(upd_cnt), 64'd1);

    // Partial word: discarded, nothing forwarded
    upd_cnt = 0; fwd_cnt = 0;
    mode = 1;
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1'(i % 3), 1, 5'(i));
      step(0, 0, 1, 5'(i));
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    mode = 0;
    chk("partial_fwd_cnt", 64'(fwd_cnt), 64'd0);
    chk("partial_upd_cnt", 64'(upd_cnt), 64'd0);
    chk("partial_leds", 64'(leds()), 64'h11223344);

    // Test mode: ramp of 300 strobes wraps to 0x2C
    upd_cnt = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 1, 5'(i));
      step(0, 0, 1, 5'(i));
    end
    tm = 1'b1;
    step(0, 0, 1, 5);
    mode = 2;
    step(1, 1, 1, 5);
    chk("test_first", 64'(leds()), 64'hFF010101);
    step(0, 0, 1, 5);
    for (int i = 1; i < 300; i++) begin
      step(1, 1'(i & 1), 1, 5'(i));
      step(0, 0, 1, 5'(i));
    end
    mode = 0;
    chk("test_ramp", 64'(leds()), 64'hFF2C2C2C);
    tm = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("test_no_update", 64'(upd_cnt), 64'd0);
    chk("test_hold", 64'(leds()), 64'hFF2C2C2C);

    // Back-to-back frames with a single idle cycle between them
    upd_cnt = 0;
    step(0, 0, 1, 0);
    send_word(32'h01020304);
    step(0, 0, 0, 0);
    chk("b2b_first", 64'(leds()), 64'h01020304);
    step(0, 0, 1, 0);
    send_word(32'h05060708);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("b2b_upd_cnt", 64'(upd_cnt), 64'd2);
    chk("b2b_leds", 64'(leds()), 64'h05060708);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
